dcache_axi_bridge: RTL and testbench
====================================

Name: dcache_axi_bridge

Overview:
Memory-side responder for the data cache's line-fill and write-back requests. Turns one cache line request (8 x 32-bit words) into a single AXI4 INCR burst on the system bus. Returns the whole line in one cycle with a grant pulse. Sits between the D-cache miss path and the AXI interconnect.

Parameters:
OFFSET_LEN, 5, byte-offset bits per line; LINE_WORDS = 2^(OFFSET_LEN-2) = 8
ADDR_W, 32, address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rd_req  in  1  line-fill request, level; held until rd_gnt
rd_addr  in  32  fill address; low OFFSET_LEN bits ignored
rd_gnt  out  1  1-cycle pulse; rd_line valid in the same cycle
rd_line  out  256  filled line; word i at bits [32i+31:32i]
wb_req  in  1  write-back request, level; held until wb_done
wb_addr  in  32  write-back line address
wb_line  in  256  dirty line; stable while wb_req is high
wb_done  out  1  1-cycle pulse when write response is accepted
araddr  out  32  AXI read address, line-aligned
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
rdata  in  32  AXI read data
rresp  in  2  AXI read response
rlast  in  1  AXI last read beat
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
awaddr  out  32  AXI write address, line-aligned
awvalid  out  1  AXI AW valid
awready  in  1  AXI AW ready
wdata  out  32  AXI write data
wlast  out  1  AXI last write beat
wvalid  out  1  AXI W valid
wready  in  1  AXI W ready
bresp  in  2  AXI write response
bvalid  in  1  AXI B valid
bready  out  1  AXI B ready
err  out  1  sticky bus error flag

Behaviour:
- Fixed burst attributes, tied at top level: arlen/awlen = LINE_WORDS-1, size = 3'b010, burst = INCR, wstrb = 4'hF, id = 0.
- States: IDLE, AR, R, RDONE, AW, W, B, WDONE.
- IDLE:
  - wb_req=1 -> AW. Write-back has priority over fill when both are high (the eviction must reach memory before the refill).
  - Otherwise rd_req=1 -> AR.
- AR:
  - arvalid=1; araddr = {rd_addr[31:OFFSET_LEN], 0}, registered on entry.
  - arvalid and araddr stay stable until arready. Handshake -> R, beat counter = 0.
- R:
  - rready=1. Each rvalid beat stores rdata into line-buffer word[beat], then beat++.
  - Beat LINE_WORDS-1 accepted -> RDONE, whatever the value of rlast.
  - rlast seen on any other beat sets err; the count still governs completion.
  - rresp != 0 on any beat sets err.
- RDONE:
  - rd_gnt=1 for exactly one cycle; rd_line = line buffer.
  - Next state is IDLE.
  - Requester must drop rd_req in the cycle after rd_gnt. In IDLE, the bridge does not sample rd_req in the cycle immediately following RDONE.
- AW:
  - awvalid=1; awaddr = {wb_addr[31:OFFSET_LEN], 0}.
  - Handshake -> W, beat = 0. AW always completes before any W beat.
- W:
  - wvalid=1; wdata = wb_line word[beat]; wlast = (beat == LINE_WORDS-1).
  - Data is held stable until wready. Each handshake increments beat.
  - Last beat accepted -> B.
- B:
  - bready=1. bvalid -> WDONE. bresp != 0 sets err.
- WDONE:
  - wb_done=1 for one cycle, then IDLE. wb_req is ignored in the cycle after WDONE.
- rd_line is registered and holds its value after rd_gnt until the next fill overwrites it.
- Beat counter is log2(LINE_WORDS) bits and never wraps inside a burst.
- Reset (asynchronous, any state):
  - State -> IDLE.
  - All valid/ready outputs, rd_gnt, wb_done and err -> 0.
  - rd_line, araddr, awaddr, wdata -> 0; beat counter -> 0.
  - Reset mid-burst abandons the transaction; the interconnect is reset by the same rst.
- err clears only on reset.

Test Plan:
- Fill: rd_req, rd_addr=0x1234_5678, arready after 2 cycles, 8 beats 0xA0..0xA7 -> araddr=0x1234_5660, rd_gnt one cycle, rd_line word0=0xA0, word7=0xA7, err=0.
- Fill with rvalid gaps (one idle cycle between beats) and rready checked -> same line assembled; rd_gnt exactly once.
- Write-back: wb_addr=0x8000_0040, wb_line words 0x10..0x17, wready toggling -> awaddr=0x8000_0040, wdata order 0x10..0x17, wlast only on the 8th beat, wb_done after bvalid.
- Simultaneous wb_req and rd_req -> AW issued first; AR only after wb_done; both complete.
- rresp=2'b10 on beat 3 -> line still completes, rd_gnt pulses, err=1 and stays 1; bresp error likewise sets err.
- rst asserted during R at beat 4 -> outputs at reset values immediately. A following fill completes normally with beat counter restarted at 0.

Source files
------------

// File: rtl/dcache_axi_bridge_if.sv
// dcache_axi_bridge_if
// AXI4 read/write bus between the D-cache line bridge and the interconnect.
// Only the channels and attributes the line bridge uses are carried.
//
// Signals:
//   AR : araddr, arlen, arsize, arburst, arid, arvalid, arready
//   R  : rdata, rresp, rlast, rvalid, rready
//   AW : awaddr, awlen, awsize, awburst, awid, awvalid, awready
//   W  : wdata, wstrb, wlast, wvalid, wready
//   B  : bresp, bvalid, bready
// Modports:
//   master : bus initiator (the bridge)
//   slave  : memory / interconnect side
interface dcache_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [ID_W-1:0]   arid;
    logic              arvalid;
    logic              arready;

    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [ID_W-1:0]   awid;
    logic              awvalid;
    logic              awready;

    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arlen, arsize, arburst, arid, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awid, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arid, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awid, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge
// Memory-side responder for D-cache line fills and write-backs. Each cache
// request becomes one AXI4 INCR burst of LINE_WORDS 32-bit beats. A fill
// returns the whole line with a one-cycle rd_gnt; a write-back ends with a
// one-cycle wb_done once the write response has been accepted.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   rd_req    : line-fill request (level, held until rd_gnt)
//   rd_addr   : fill address, low OFFSET_LEN bits ignored
//   rd_gnt    : one-cycle pulse, rd_line valid in the same cycle
//   rd_line   : filled line, word i at bits [32i+31:32i]; held until next fill
//   wb_req    : write-back request (level, held until wb_done)
//   wb_addr   : write-back line address
//   wb_line   : dirty line, stable while wb_req is high
//   wb_done   : one-cycle pulse when the write response is accepted
//   err       : sticky bus error flag, cleared only by reset
//   axi       : AXI4 master port (dcache_axi_bridge_if.master)
module dcache_axi_bridge #(
    parameter int OFFSET_LEN = 5,
    parameter int ADDR_W     = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rd_req,
    input  logic [ADDR_W-1:0]                   rd_addr,
    output logic                                rd_gnt,
    output logic [(32 << (OFFSET_LEN-2))-1:0]   rd_line,
    input  logic                                wb_req,
    input  logic [ADDR_W-1:0]                   wb_addr,
    input  logic [(32 << (OFFSET_LEN-2))-1:0]   wb_line,
    output logic                                wb_done,
    output logic                                err,
    dcache_axi_bridge_if.master                 axi
);

    localparam int LINE_WORDS = 2 ** (OFFSET_LEN - 2);
    localparam int BEAT_W     = OFFSET_LEN - 2;
    localparam int LINE_BITS  = 32 * LINE_WORDS;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        RDONE,
        AW,
        W,
        B,
        WDONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [BEAT_W-1:0]   beat;
    logic [ADDR_W-1:0]   araddr_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [LINE_BITS-1:0] line_buf;
    logic                err_q;
    logic                skip_rd;
    logic                skip_wb;

    // Line-offset address bits are dropped by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr[OFFSET_LEN-1:0], wb_addr[OFFSET_LEN-1:0]};

    // Fixed burst shape: one full line, 4-byte beats, incrementing, id 0.
    assign axi.arlen   = 8'(LINE_WORDS - 1);
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arid    = '0;
    assign axi.awlen   = 8'(LINE_WORDS - 1);
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.awid    = '0;
    assign axi.wstrb   = 4'hF;

    assign axi.araddr = araddr_q;
    assign axi.awaddr = awaddr_q;
    assign rd_line    = line_buf;
    assign err        = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Write-back wins over fill so an evicted line reaches memory before the
    // refill that replaces it. The skip flags mask the request that was just
    // served for one IDLE cycle while the requester drops its level.
    always_comb begin
        state_next  = state;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.wlast   = 1'b0;
        axi.wdata   = '0;
        axi.bready  = 1'b0;
        rd_gnt      = 1'b0;
        wb_done     = 1'b0;
        case (state)
            IDLE: begin
                if (wb_req && !skip_wb) begin
                    state_next = AW;
                end else if (rd_req && !skip_rd) begin
                    state_next = AR;
                end
            end
            AR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) begin
                    state_next = R;
                end
            end
            R: begin
                axi.rready = 1'b1;
                if (axi.rvalid && (beat == LAST_BEAT)) begin
                    state_next = RDONE;
                end
            end
            RDONE: begin
                rd_gnt     = 1'b1;
                state_next = IDLE;
            end
            AW: begin
                axi.awvalid = 1'b1;
                if (axi.awready) begin
                    state_next = W;
                end
            end
            W: begin
                axi.wvalid = 1'b1;
                axi.wdata  = wb_line[{beat, 5'd0} +: 32];
                axi.wlast  = (beat == LAST_BEAT);
                if (axi.wready && (beat == LAST_BEAT)) begin
                    state_next = B;
                end
            end
            B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    state_next = WDONE;
                end
            end
            WDONE: begin
                wb_done    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Burst datapath. The beat counter saturates at LAST_BEAT; completion is
    // decided by the count alone, so an early rlast only flags an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat     <= '0;
            araddr_q <= '0;
            awaddr_q <= '0;
            line_buf <= '0;
            err_q    <= 1'b0;
            skip_rd  <= 1'b0;
            skip_wb  <= 1'b0;
        end else begin
            skip_rd <= (state == RDONE);
            skip_wb <= (state == WDONE);
            case (state)
                IDLE: begin
                    if (state_next == AR) begin
                        araddr_q <= {rd_addr[ADDR_W-1:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
                    end else if (state_next == AW) begin
                        awaddr_q <= {wb_addr[ADDR_W-1:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
                    end
                end
                AR: begin
                    if (axi.arready) begin
                        beat <= '0;
                    end
                end
                R: begin
                    if (axi.rvalid) begin
                        line_buf[{beat, 5'd0} +: 32] <= axi.rdata;
                        if (axi.rresp != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        if (axi.rlast && (beat != LAST_BEAT)) begin
                            err_q <= 1'b1;
                        end
                        if (beat != LAST_BEAT) begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                AW: begin
                    if (axi.awready) begin
                        beat <= '0;
                    end
                end
                W: begin
                    if (axi.wready && (beat != LAST_BEAT)) begin
                        beat <= beat + 1'b1;
                    end
                end
                B: begin
                    if (axi.bvalid && (axi.bresp != 2'b00)) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// tb_dcache_axi_bridge
// Scoreboard bench for dcache_axi_bridge. Requests push their expected AXI
// addresses, write beats and filled lines into queues; a bus model serves the
// bursts and pops/compares as the bridge produces them. A monitor pops the
// expected line on every rd_gnt.
module tb_dcache_axi_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         rd_gnt;
    logic [255:0] rd_line;
    logic         wb_req;
    logic [31:0]  wb_addr;
    logic [255:0] wb_line;
    logic         wb_done;
    logic         err;

    dcache_axi_bridge_if #(.ADDR_W(32)) axi ();

    dcache_axi_bridge #(.OFFSET_LEN(5), .ADDR_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_gnt  (rd_gnt),
        .rd_line (rd_line),
        .wb_req  (wb_req),
        .wb_addr (wb_addr),
        .wb_line (wb_line),
        .wb_done (wb_done),
        .err     (err),
        .axi     (axi)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int gnt_count = 0;
    int g0;

    logic [255:0] exp_line_q[$];
    logic [31:0]  exp_ar_q[$];
    logic [31:0]  exp_aw_q[$];
    logic [31:0]  exp_w_q[$];

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ctrl"},
                    {rd_gnt, wb_done, err, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid,
                     axi.bready, axi.araddr, axi.awaddr, axi.wdata}, '0);
        checkOutput({tag, "_line"}, rd_line, '0);
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    // Raises a cache request and records what the bus and the cache must see.
    task automatic applyStimulus(input bit is_wb, input logic [31:0] addr, input logic [255:0] line);
        if (is_wb) begin
            wb_req  = 1'b1;
            wb_addr = addr;
            wb_line = line;
            exp_aw_q.push_back({addr[31:5], 5'b0});
            for (int i = 0; i < 8; i++) exp_w_q.push_back(line[32*i +: 32]);
        end else begin
            rd_req  = 1'b1;
            rd_addr = addr;
            exp_ar_q.push_back({addr[31:5], 5'b0});
            exp_line_q.push_back(line);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rd_gnt) begin
            gnt_count++;
            if (exp_line_q.size() == 0) begin
                checkOutput("unexpected_rd_gnt", rd_gnt, 1'b0);
            end else begin
                checkOutput("rd_line", rd_line, exp_line_q.pop_front());
            end
        end
    end

    task automatic serve_read(input int ar_delay, input bit gaps, input int err_beat,
                              input int abort_beat, input logic [255:0] data);
        int n;
        logic [31:0] exp_ar;
        n = 0;
        while (!axi.arvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("arvalid", axi.arvalid, 1'b1);
        if (!axi.arvalid) return;
        exp_ar = exp_ar_q.pop_front();
        checkOutput("araddr", axi.araddr, exp_ar);
        repeat (ar_delay) @(negedge clk);
        checkOutput("ar_held", {axi.arvalid, axi.araddr}, {1'b1, exp_ar});
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == abort_beat) begin
                rst = 1'b1;
                #1;
                checkReset("reset_mid_burst");
                axi.rvalid = 1'b0;
                rd_req     = 1'b0;
                exp_line_q.delete(exp_line_q.size() - 1);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (gaps && i > 0) begin
                axi.rvalid = 1'b0;
                @(negedge clk);
            end
            checkOutput("rready", axi.rready, 1'b1);
            axi.rvalid = 1'b1;
            axi.rdata  = data[32*i +: 32];
            axi.rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            axi.rlast  = (i == 7);
            @(negedge clk);
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'b00;
    endtask

    // Holds rd_req through the IDLE cycle after the grant; the bridge must not refetch.
    task automatic finish_fill();
        int n;
        n = 0;
        while (!rd_gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rd_gnt_seen", rd_gnt, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rd_req = 1'b0;
        @(negedge clk);
        checkOutput("rd_gnt_pulse", {rd_gnt, axi.arvalid}, 2'b00);
    endtask

    task automatic serve_write(input bit toggle, input bit berr);
        int n;
        int acc;
        n = 0;
        acc = 0;
        while (!axi.awvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("awvalid", axi.awvalid, 1'b1);
        if (!axi.awvalid) return;
        checkOutput("aw_first", {axi.wvalid, axi.arvalid}, 2'b00);
        checkOutput("awaddr", axi.awaddr, exp_aw_q.pop_front());
        axi.awready = 1'b1;
        @(negedge clk);
        axi.awready = 1'b0;
        n = 0;
        while (acc < 8 && n < 100) begin
            axi.wready = toggle ? n[0] : 1'b1;
            #1;
            checkOutput("wvalid", axi.wvalid, 1'b1);
            checkOutput("wdata", axi.wdata, exp_w_q[0]);
            checkOutput("wlast", axi.wlast, (acc == 7));
            if (axi.wvalid && axi.wready) begin
                exp_w_q.delete(0);
                acc++;
            end
            @(negedge clk);
            n++;
        end
        axi.wready = 1'b0;
        checkOutput("w_beats", acc, 8);
        n = 0;
        while (!axi.bready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bready", {axi.bready, axi.wvalid, axi.arvalid}, 3'b100);
        axi.bvalid = 1'b1;
        axi.bresp  = berr ? 2'b10 : 2'b00;
        @(negedge clk);
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        checkOutput("wb_done", wb_done, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 wb_req = 1'b0;
        @(negedge clk);
        checkOutput("wb_done_pulse", {wb_done, axi.awvalid}, 2'b00);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        rd_req      = 1'b0;
        rd_addr     = '0;
        wb_req      = 1'b0;
        wb_addr     = '0;
        wb_line     = '0;
        axi.arready = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        axi.rvalid  = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bvalid  = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("reset");
        checkOutput("burst_attrs",
                    {axi.arlen, axi.arsize, axi.arburst, axi.arid,
                     axi.awlen, axi.awsize, axi.awburst, axi.awid, axi.wstrb},
                    {8'd7, 3'b010, 2'b01, 4'd0, 8'd7, 3'b010, 2'b01, 4'd0, 4'hF});
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic fill");
        g0 = gnt_count;
        applyStimulus(1'b0, 32'h1234_5678, make_line(32'hA0));
        serve_read(2, 1'b0, -1, -1, make_line(32'hA0));
        finish_fill();
        checkOutput("fill_gnt_once", gnt_count - g0, 1);
        checkOutput("fill_err", err, 1'b0);

        $display("[TB] fill with rvalid gaps");
        g0 = gnt_count;
        applyStimulus(1'b0, 32'h0000_1004, make_line(32'hB0));
        serve_read(0, 1'b1, -1, -1, make_line(32'hB0));
        finish_fill();
        checkOutput("gap_gnt_once", gnt_count - g0, 1);
        checkOutput("line_held", rd_line, make_line(32'hB0));

        $display("[TB] write-back with wready toggling");
        applyStimulus(1'b1, 32'h8000_0040, make_line(32'h10));
        serve_write(1'b1, 1'b0);
        checkOutput("wb_err", err, 1'b0);

        $display("[TB] simultaneous write-back and fill");
        g0 = gnt_count;
        applyStimulus(1'b1, 32'h4000_0100, make_line(32'h20));
        applyStimulus(1'b0, 32'h4000_0200, make_line(32'hC0));
        serve_write(1'b0, 1'b0);
        serve_read(1, 1'b0, -1, -1, make_line(32'hC0));
        finish_fill();
        checkOutput("both_gnt_once", gnt_count - g0, 1);

        $display("[TB] read response error");
        applyStimulus(1'b0, 32'h0000_2000, make_line(32'hD0));
        serve_read(0, 1'b0, 3, -1, make_line(32'hD0));
        finish_fill();
        checkOutput("rresp_err", err, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("err_sticky", err, 1'b1);

        $display("[TB] reset mid-burst then fill");
        g0 = gnt_count;
        applyStimulus(1'b0, 32'h0000_3000, make_line(32'hE0));
        serve_read(1, 1'b0, -1, 4, make_line(32'hE0));
        applyStimulus(1'b0, 32'h0000_3020, make_line(32'hF0));
        serve_read(0, 1'b0, -1, -1, make_line(32'hF0));
        finish_fill();
        checkOutput("post_reset_gnt_once", gnt_count - g0, 1);
        checkOutput("post_reset_err", err, 1'b0);

        $display("[TB] write response error");
        applyStimulus(1'b1, 32'h0000_4000, make_line(32'h30));
        serve_write(1'b0, 1'b1);
        checkOutput("bresp_err", err, 1'b1);

        checkOutput("scoreboard_empty",
                    exp_line_q.size() + exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
